ann_q_max_issue: RTL and testbench
==================================

Name: ann_q_max_issue

Overview:
- Producer side of the DQN target computation.
- Collects the NUM_ACTIONS next-state Q values streamed out of the target network, selects the IEEE-754 single-precision maximum and its action index, and pairs the result with the replay-memory sample's reward/done.
- Issues q_max and reward/done as one single-cycle valid pulse each, on the same cycle, into the loss/target stage (q_max valid, reward valid, done inputs).

Parameters:
- DATA_WIDTH, 32, float word width; IEEE-754 single only.
- NUM_ACTIONS, 4, Q values per state; legal range 2..16.
- IDX_WIDTH, 2, action index width; must satisfy 2^IDX_WIDTH >= NUM_ACTIONS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_q_valid  in  1  Q value strobe; accepted only when o_q_ready=1
- i_q_value  in  DATA_WIDTH  Q(s',a), actions arrive in index order 0..NUM_ACTIONS-1
- o_q_ready  out  1  block can accept a Q value
- i_sample_valid  in  1  reward/done strobe; accepted only when o_sample_ready=1
- i_reward  in  DATA_WIDTH  float reward
- i_done  in  1  terminal-state flag
- o_sample_ready  out  1  no sample held
- o_q_max_valid  out  1  one-cycle issue pulse
- o_q_max  out  DATA_WIDTH  max Q value
- o_q_max_idx  out  IDX_WIDTH  argmax action index
- o_reward_valid  out  1  one-cycle pulse, identical timing to o_q_max_valid
- o_reward  out  DATA_WIDTH  latched reward
- o_done  out  1  latched done

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except o_q_ready=1 and o_sample_ready=1. Counter, running max, running index, sample register and flags all cleared.
- Q side, states Q_ACCUM and Q_FULL; reset state is Q_ACCUM with cnt=0.
  - Q_ACCUM, o_q_ready=1. On an accepted beat:
    - cnt=0: max<=value, idx<=0 unconditionally.
    - cnt>0: if value > max (compare rule below), max<=value and idx<=cnt.
    - cnt increments by 1.
    - On the beat with cnt=NUM_ACTIONS-1: cnt wraps to 0 and the state goes to Q_FULL.
  - Q_FULL, o_q_ready=0; i_q_valid is ignored. Returns to Q_ACCUM on the issue cycle.
- Sample side:
  - Accept when i_sample_valid and o_sample_ready: latch reward and done, set sample_held, and o_sample_ready<=0.
  - i_sample_valid is ignored while a sample is held.
- Issue:
  - Condition: the cycle after both Q_FULL and sample_held are true.
  - Registered outputs: o_q_max_valid=o_reward_valid=1 for exactly one cycle, with o_q_max, o_q_max_idx, o_reward, o_done updated on that same edge.
  - On the same edge: sample_held clears and Q returns to Q_ACCUM, so o_q_ready=o_sample_ready=1 the following cycle.
  - Data outputs hold their value between pulses.
- Latency: last Q beat and sample both accepted by edge T gives the pulse visible after edge T+1. A last Q beat and a sample in the same cycle are legal: both are captured, and the issue follows on the next edge.
- Float compare (a > b):
  - Signs differ: the positive operand is greater. +0 and -0 compare equal, i.e. not greater.
  - Both positive: unsigned compare of bits[30:0].
  - Both negative: the smaller bits[30:0] is greater.
  - Equal values: the earlier index is kept (ties go to the lowest index).
  - NaN/Inf: not special-cased; the raw bit rules above apply.
- done=1 still issues the computed q_max; suppressing it is the downstream stage's job.
- Reset mid-accumulation discards the partial max and any held sample. No pulse is produced.
- Back-to-back: the next state's Q beats may start the cycle after the issue pulse, giving a sustained rate of one issue per NUM_ACTIONS+1 cycles.

Test Plan:
1. Q = 3F800000, 40200000, BF800000, 3F000000, with sample (reward 3F800000, done 0) sent first → one pulse; q_max 40200000, idx 1, reward 3F800000, done 0.
2. All negative Q = BF800000, C0400000, BF000000, C0400000 → q_max BF000000, idx 2.
3. Ties and zero sign: 3F800000, 3F800000, 80000000, 00000000 → idx 0. Also -0 then +0 at indices 0/1 with the rest negative → idx 0.
4. Sample arrives 5 cycles after the last Q (done=1, reward BF800000) → o_q_ready low until the pulse; pulse 1 cycle after the sample is accepted; o_done 1. Extra i_q_valid beats while full are ignored.
5. Last Q beat and sample in the same cycle → pulse on the next edge. A second sample presented while one is held is dropped (o_sample_ready=0).
6. Assert rst_n after 2 of 4 Q beats → no pulse; all outputs 0, both readys 1. A fresh 4-beat set then yields the correct max.

Source files
------------

// File: rtl/ann_q_max_issue.sv
// ann_q_max_issue
// Producer side of the DQN target computation. Collects NUM_ACTIONS next-state
// Q values (IEEE-754 single) from the target network, keeps the running
// maximum and its action index, pairs the result with one replay-memory
// sample (reward/done) and issues everything as a single-cycle pulse.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_q_valid/i_q_value/o_q_ready    Q value stream, actions in index order
//   i_sample_valid/i_reward/i_done   replay sample, o_sample_ready = none held
//   o_q_max_valid/o_q_max/o_q_max_idx  issued maximum and argmax
//   o_reward_valid/o_reward/o_done     issued sample, same cycle as q_max
module ann_q_max_issue #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ACTIONS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_q_valid,
  input  logic [DATA_WIDTH-1:0] i_q_value,
  output logic                  o_q_ready,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_reward,
  input  logic                  i_done,
  output logic                  o_sample_ready,
  output logic                  o_q_max_valid,
  output logic [DATA_WIDTH-1:0] o_q_max,
  output logic [IDX_WIDTH-1:0]  o_q_max_idx,
  output logic                  o_reward_valid,
  output logic [DATA_WIDTH-1:0] o_reward,
  output logic                  o_done
);

  typedef enum logic {Q_ACCUM, Q_FULL} q_state_t;

  q_state_t              state, state_nxt;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] max_r;
  logic [IDX_WIDTH-1:0]  idx_r;
  logic [DATA_WIDTH-1:0] reward_r;
  logic                  done_r;
  logic                  sample_held;

  logic q_acc, s_acc, issue, last_beat;

  // Raw-bit float compare a > b. Sign-magnitude ordering; +0 and -0 are
  // equal. NaN/Inf are ordered by their bit patterns like any other value.
  function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma, mb;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      if (ma == '0 && mb == '0) fp_gt = 1'b0;
      else                      fp_gt = ~a[DATA_WIDTH-1];
    end else if (!a[DATA_WIDTH-1]) begin
      fp_gt = (ma > mb);
    end else begin
      fp_gt = (ma < mb);
    end
  endfunction

  assign o_q_ready      = (state == Q_ACCUM);
  assign o_sample_ready = ~sample_held;
  assign q_acc          = i_q_valid && o_q_ready;
  assign s_acc          = i_sample_valid && o_sample_ready;
  assign last_beat      = (cnt == IDX_WIDTH'(NUM_ACTIONS - 1));
  // Both halves present: issue on this edge, which also releases both sides.
  assign issue          = (state == Q_FULL) && sample_held;

  always_comb begin
    state_nxt = state;
    case (state)
      Q_ACCUM: if (q_acc && last_beat) state_nxt = Q_FULL;
      Q_FULL:  if (issue)              state_nxt = Q_ACCUM;
      default:                         state_nxt = Q_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= Q_ACCUM;
    else        state <= state_nxt;
  end

  // Q accumulation: first beat seeds the max, later beats replace it only
  // when strictly greater so ties keep the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      max_r <= '0;
      idx_r <= '0;
    end else if (q_acc) begin
      if (cnt == '0) begin
        max_r <= i_q_value;
        idx_r <= '0;
      end else if (fp_gt(i_q_value, max_r)) begin
        max_r <= i_q_value;
        idx_r <= cnt;
      end
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  // Sample holding register; new samples are refused while one is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reward_r    <= '0;
      done_r      <= 1'b0;
      sample_held <= 1'b0;
    end else if (issue) begin
      sample_held <= 1'b0;
    end else if (s_acc) begin
      reward_r    <= i_reward;
      done_r      <= i_done;
      sample_held <= 1'b1;
    end
  end

  // Issue stage: registered pulse, data held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q_max_valid  <= 1'b0;
      o_reward_valid <= 1'b0;
      o_q_max        <= '0;
      o_q_max_idx    <= '0;
      o_reward       <= '0;
      o_done         <= 1'b0;
    end else begin
      o_q_max_valid  <= issue;
      o_reward_valid <= issue;
      if (issue) begin
        o_q_max     <= max_r;
        o_q_max_idx <= idx_r;
        o_reward    <= reward_r;
        o_done      <= done_r;
      end
    end
  end

endmodule

// File: tb/tb_ann_q_max_issue.sv
module tb_ann_q_max_issue;
  localparam int DW = 32;
  localparam int NA = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_q_valid = 1'b0;
  logic [DW-1:0] i_q_value = '0;
  logic          o_q_ready;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_reward = '0;
  logic          i_done = 1'b0;
  logic          o_sample_ready;
  logic          o_q_max_valid;
  logic [DW-1:0] o_q_max;
  logic [IW-1:0] o_q_max_idx;
  logic          o_reward_valid;
  logic [DW-1:0] o_reward;
  logic          o_done;

  ann_q_max_issue #(.DATA_WIDTH(DW), .NUM_ACTIONS(NA), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_q_valid(i_q_valid), .i_q_value(i_q_value), .o_q_ready(o_q_ready),
    .i_sample_valid(i_sample_valid), .i_reward(i_reward), .i_done(i_done),
    .o_sample_ready(o_sample_ready),
    .o_q_max_valid(o_q_max_valid), .o_q_max(o_q_max), .o_q_max_idx(o_q_max_idx),
    .o_reward_valid(o_reward_valid), .o_reward(o_reward), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Q values of the current state in a queue, sample held as a flag; a float
  // is ordered by mapping sign-magnitude onto a signed integer (-0 == +0).
  logic [DW-1:0] m_q[$];
  bit            m_held = 0;
  logic [DW-1:0] m_rew = '0;
  bit            m_dn = 0;
  bit            e_vld = 0;
  logic [DW-1:0] e_max = '0;
  logic [IW-1:0] e_idx = '0;
  logic [DW-1:0] e_rew = '0;
  bit            e_dn = 0;

  function automatic longint fkey(input logic [DW-1:0] v);
    longint m;
    m = longint'(v[DW-2:0]);
    return v[DW-1] ? -m : m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_held = 0; m_rew = '0; m_dn = 0;
      e_vld = 0; e_max = '0; e_idx = '0; e_rew = '0; e_dn = 0;
    end else if (m_q.size() == NA && m_held) begin
      int best;
      best = 0;
      for (int i = 1; i < NA; i++)
        if (fkey(m_q[i]) > fkey(m_q[best])) best = i;
      e_vld = 1; e_max = m_q[best]; e_idx = IW'(best);
      e_rew = m_rew; e_dn = m_dn;
      m_q.delete();
      m_held = 0;
    end else begin
      e_vld = 0;
      if (i_q_valid && m_q.size() < NA) m_q.push_back(i_q_value);
      if (i_sample_valid && !m_held) begin
        m_held = 1; m_rew = i_reward; m_dn = i_done;
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    chk("q_ready",      64'(o_q_ready),      64'(m_q.size() < NA));
    chk("sample_ready", 64'(o_sample_ready), 64'(!m_held));
    chk("q_max_valid",  64'(o_q_max_valid),  64'(e_vld));
    chk("reward_valid", 64'(o_reward_valid), 64'(e_vld));
    chk("q_max",        64'(o_q_max),        64'(e_max));
    chk("q_max_idx",    64'(o_q_max_idx),    64'(e_idx));
    chk("reward",       64'(o_reward),       64'(e_rew));
    chk("done",         64'(o_done),         64'(e_dn));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit qv, input logic [DW-1:0] qd,
                     input bit sv, input logic [DW-1:0] rw, input bit dn);
    @(negedge clk);
    i_q_valid = qv; i_q_value = qd;
    i_sample_valid = sv; i_reward = rw; i_done = dn;
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, 0);
  endtask

  task automatic q4(input logic [DW-1:0] a, b, c, d);
    cyc(1, a, 0, '0, 0); cyc(1, b, 0, '0, 0);
    cyc(1, c, 0, '0, 0); cyc(1, d, 0, '0, 0);
  endtask

  // Bounded wait for the pulse, then pin the literal expectations.
  task automatic wait_pulse(input string nm, input logic [DW-1:0] mx,
                            input logic [IW-1:0] ix, input logic [DW-1:0] rw, input bit dn);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      if (o_q_max_valid) seen = 1;
    end
    chk({nm, "_pulse_seen"}, 64'(seen), 64'd1);
    chk({nm, "_q_max"},      64'(o_q_max), 64'(mx));
    chk({nm, "_idx"},        64'(o_q_max_idx), 64'(ix));
    chk({nm, "_reward"},     64'(o_reward), 64'(rw));
    chk({nm, "_done"},       64'(o_done), 64'(dn));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q_ready", 64'(o_q_ready), 64'd1);
    chk("rst_sample_ready", 64'(o_sample_ready), 64'd1);
    chk("rst_outs", 64'({o_q_max_valid, o_reward_valid, o_q_max, o_q_max_idx, o_reward, o_done}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: sample first, mixed positives/negatives
    cyc(0, '0, 1, 32'h3F800000, 0);
    q4(32'h3F800000, 32'h40200000, 32'hBF800000, 32'h3F000000);
    idle();
    wait_pulse("t1", 32'h40200000, 2'd1, 32'h3F800000, 0);

    // 2: all negative
    cyc(0, '0, 1, 32'h40000000, 0);
    q4(32'hBF800000, 32'hC0400000, 32'hBF000000, 32'hC0400000);
    idle();
    wait_pulse("t2", 32'hBF000000, 2'd2, 32'h40000000, 0);

    // 3: ties and signed zeros
    cyc(0, '0, 1, 32'h00000000, 0);
    q4(32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000);
    idle();
    wait_pulse("t3a", 32'h3F800000, 2'd0, 32'h00000000, 0);
    cyc(0, '0, 1, 32'h3F800000, 1);
    q4(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000);
    idle();
    wait_pulse("t3b", 32'h80000000, 2'd0, 32'h3F800000, 1);

    // 4: sample late; extra Q beats while full must be ignored
    q4(32'h00000000, 32'h41000000, 32'h40000000, 32'h3F800000);
    for (int i = 0; i < 5; i++) cyc(1, 32'h7F000000, 0, '0, 0);
    #7;
    chk("t4_q_ready_low", 64'(o_q_ready), 64'd0);
    cyc(0, '0, 1, 32'hBF800000, 1);
    @(posedge clk); #2;
    chk("t4_no_pulse_at_accept", 64'(o_q_max_valid), 64'd0);
    idle();
    @(posedge clk); #2;
    chk("t4_pulse", 64'(o_q_max_valid), 64'd1);
    chk("t4_q_max", 64'(o_q_max), 64'h41000000);
    chk("t4_idx", 64'(o_q_max_idx), 64'd1);
    chk("t4_done", 64'(o_done), 64'd1);
    chk("t4_reward", 64'(o_reward), 64'hBF800000);

    // 5: last Q and sample together, second sample dropped
    cyc(1, 32'h40400000, 0, '0, 0);
    cyc(1, 32'h40800000, 0, '0, 0);
    cyc(1, 32'h40A00000, 0, '0, 0);
    cyc(1, 32'h3F800000, 1, 32'h40000000, 0);
    @(posedge clk); #2;
    chk("t5_no_pulse_at_accept", 64'(o_q_max_valid), 64'd0);
    chk("t5_sample_ready_low", 64'(o_sample_ready), 64'd0);
    cyc(0, '0, 1, 32'h40400000, 1);
    @(posedge clk); #2;
    chk("t5_pulse", 64'(o_q_max_valid), 64'd1);
    chk("t5_q_max", 64'(o_q_max), 64'h40A00000);
    chk("t5_idx", 64'(o_q_max_idx), 64'd2);
    chk("t5_reward", 64'(o_reward), 64'h40000000);
    idle();

    // 6: reset mid-accumulation
    cyc(0, '0, 1, 32'h3F800000, 0);
    cyc(1, 32'h42000000, 0, '0, 0);
    cyc(1, 32'h3F800000, 0, '0, 0);
    idle();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_outs", 64'({o_q_max_valid, o_reward_valid, o_q_max, o_q_max_idx, o_reward, o_done}), 64'd0);
    chk("t6_rst_readys", 64'({o_q_ready, o_sample_ready}), 64'd3);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, '0, 1, 32'hC0000000, 0);
    q4(32'hC0800000, 32'hC0000000, 32'h3E800000, 32'h3E800000);
    idle();
    wait_pulse("t6", 32'h3E800000, 2'd2, 32'hC0000000, 0);

    // Random traffic against the model, values drawn to include ties/zeros
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] v, r;
      case ($urandom_range(0, 4))
        0: v = 32'h00000000;
        1: v = 32'h80000000;
        2: v = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 7)) << 23};
        default: v = $urandom;
      endcase
      r = $urandom;
      cyc($urandom_range(0, 2) != 0, v, $urandom_range(0, 3) == 0, r, $urandom_range(0, 1) == 1);
    end
    idle();
    repeat (10) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
